sd_result_arbiter: RTL
======================

Name: sd_result_arbiter

Overview:
Collects filtered results from the two sigma-delta channels, buffers each channel in its own small FIFO, and shares a single host read port between them. The host can read per channel, or use a round-robin arbitrated read. Maintains sticky status flags, an interrupt-enable mask and the IRQ output. Sits between the SD channel instances and the host bus (RD/WR/ADDR/DATA) inside the SDFM top level.

Parameters:
DW, 32, result data width per channel.
DEPTH, 4, FIFO depth per channel; must be a power of 2, at least 2.
AW, 8, host address width.

Ports:
SYSCLK  in  1  system clock; all inputs are synchronous to it.
EXTRSTn  in  1  reset, asynchronous, active-low.
ch_data  in  2*DW  result words; channel i occupies bits [DW*i+DW-1 : DW*i].
ch_valid  in  2  one-cycle strobe per channel; ch_data[i] is valid in that cycle.
RD  in  1  host read, level.
WR  in  1  host write, level.
ADDR  in  AW  host address.
WDATA  in  32  host write data.
RDATA  out  32  host read data, registered.
IRQ  out  1  interrupt request, registered, active-high.

Behaviour:
- Reset (async on EXTRSTn low): FIFOs empty, pointers 0, RDATA=0, IRQ=0, IER=0, overflow flags=0, last_grant=1 (so ch0 wins first), ARBID=2.
- Edge detection: rd_q and wr_q are registered copies of RD and WR. An access fires only in the cycle where RD&!rd_q (or WR&!wr_q). A long RD or WR level gives exactly one access.
- Register map (byte addresses):
  - 0x00 STAT (RO): [1:0] not_empty, [3:2] full, [5:4] ovf, [7:6] pending. Other bits read 0.
  - 0x04 IER (RW): [1:0] data-ready enables, [3:2] overflow enables. Other bits ignored and read 0.
  - 0x08 ICLR (WO): writing 1 to bit [5:4] clears ovf[1:0]. Reads return 0.
  - 0x10 DATA0 / 0x14 DATA1 (RO, popping): head of FIFO0 or FIFO1.
  - 0x18 ARBDATA (RO, popping): round-robin pop.
  - 0x1C ARBID (RO): [1:0] = channel of the last ARBDATA pop (0/1), or 2 if that pop found both FIFOs empty.
  - Unmapped addresses read 0; writes to them are ignored.
- Read timing: on the RD rising-edge cycle, RDATA <= selected value and the pop happens in the same cycle. RDATA is valid from the next cycle and is held until the next read edge.
- Empty pop: RDATA <= 0; pointers and count unchanged; no error flag.
- Push: on ch_valid[i], write to FIFO i when not full, and count increments.
  - Full and no pop in the same cycle: word dropped, ovf[i] <= 1 (sticky).
  - Full with a pop in the same cycle: push accepted, count unchanged, no overflow.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect. On an empty FIFO: the pop returns 0 (empty-pop rule), the push is stored, count becomes 1.
- ICLR write and a new overflow on the same channel in the same cycle: set wins (flag stays 1).
- Round-robin on ARBDATA:
  - Both not empty: grant = !last_grant.
  - Exactly one not empty: grant that channel.
  - Both empty: RDATA=0, ARBID=2, last_grant unchanged.
  - On a successful grant: last_grant <= grant and ARBID <= grant.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1. full = (count==DEPTH).
- pending[i] = (not_empty[i] & IER[i]) | (ovf[i] & IER[i+2]).
- IRQ <= |pending, registered, so one cycle of latency after the causing event.
- Reset asserted mid-operation clears everything immediately. Reads in flight are lost.

Decomposition:
- Shared package sd_pkg:
  - address constants SD_ADDR_STAT/IER/ICLR/DATA0/DATA1/ARBDATA/ARBID;
  - STAT bit-field positions;
  - SD_NUM_CH=2;
  - ARBID_NONE=2.
- One sub-module sd_fifo (synchronous FIFO, DEPTH x DW) with push, pop, rdata (head, combinational), count, full, empty, and async active-low reset. Instantiated twice.
- Top logic holds the bus decode, edge detect, arbiter, flags and IRQ.

Test Plan:
- Reset and empty reads: after reset, read STAT -> 0; read DATA0 -> 0; read ARBID -> 2; IRQ = 0.
- FIFO order: push ch0 values 0x11, 0x22, 0x33. Three DATA0 reads -> 0x11, 0x22, 0x33. A fourth read -> 0. STAT[0] = 0 at the end.
- Overflow:
  - push 5 words to ch1 with DEPTH=4 -> STAT[3]=1, STAT[5]=1; reads return the first 4 words.
  - write ICLR=0x20 -> STAT[5]=0.
- Round-robin: fill ch0 with A0, A1 and ch1 with B0, B1. Four ARBDATA reads -> A0, B0, A1, B1, with ARBID 0, 1, 0, 1. A fifth read -> 0 and ARBID=2.
- IRQ: set IER=0x1, push ch0 -> IRQ rises 1 cycle after the push; DATA0 read -> IRQ falls 1 cycle after the pop. Set IER=0x8 and overflow ch1 -> IRQ=1 until ICLR=0x20.
- Corner cases:
  - push on full ch0 in the same cycle as a DATA0 read edge -> no overflow, count stays 4;
  - hold RD high for 10 cycles -> exactly one pop;
  - assert EXTRSTn low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg
// Shared constants for the sigma-delta result arbiter: host register
// addresses, STAT bit-field positions, channel count and the ARBID value
// that means "no channel granted".
package sd_pkg;

    localparam int SD_NUM_CH = 2;

    localparam logic [1:0] ARBID_NONE = 2'd2;

    // Host register byte addresses
    localparam logic [7:0] SD_ADDR_STAT    = 8'h00;
    localparam logic [7:0] SD_ADDR_IER     = 8'h04;
    localparam logic [7:0] SD_ADDR_ICLR    = 8'h08;
    localparam logic [7:0] SD_ADDR_DATA0   = 8'h10;
    localparam logic [7:0] SD_ADDR_DATA1   = 8'h14;
    localparam logic [7:0] SD_ADDR_ARBDATA = 8'h18;
    localparam logic [7:0] SD_ADDR_ARBID   = 8'h1C;

    // STAT field LSB positions, two bits each (one per channel)
    localparam int SD_STAT_NE_LSB   = 0;
    localparam int SD_STAT_FULL_LSB = 2;
    localparam int SD_STAT_OVF_LSB  = 4;
    localparam int SD_STAT_PEND_LSB = 6;

endpackage

// File: rtl/sd_result_arbiter_if.sv
// sd_result_arbiter_if
// Host bus between the SDFM host side and the result arbiter.
//   RD, WR   level strobes from the host (edge-detected in the slave)
//   ADDR     byte address, AW bits
//   WDATA    write data
//   RDATA    registered read data
//   IRQ      registered interrupt request
interface sd_result_arbiter_if #(
    parameter int AW = 8
);
    logic          RD;
    logic          WR;
    logic [AW-1:0] ADDR;
    logic [31:0]   WDATA;
    logic [31:0]   RDATA;
    logic          IRQ;

    modport master (output RD, WR, ADDR, WDATA, input RDATA, IRQ);
    modport slave  (input RD, WR, ADDR, WDATA, output RDATA, IRQ);
endinterface

// File: rtl/sd_fifo.sv
// sd_fifo
// Synchronous DEPTH x DW FIFO with a combinational head output.
//   SYSCLK, EXTRSTn  clock, async active-low reset
//   push, wdata      write request and data
//   pop              read request (ignored when empty)
//   rdata            head word (undefined when empty)
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags
// A push on a full FIFO is accepted only when a pop happens in the same
// cycle; the freed slot is the one being written.
module sd_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   SYSCLK,
    input  logic                   EXTRSTn,
    input  logic                   push,
    input  logic [DW-1:0]          wdata,
    input  logic                   pop,
    output logic [DW-1:0]          rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage has no reset so it can map onto plain RAM cells
    always_ff @(posedge SYSCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge SYSCLK or negedge EXTRSTn) begin
        if (!EXTRSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/sd_result_arbiter.sv
// sd_result_arbiter
// Buffers the filtered results of the two SD channels in per-channel FIFOs
// and exposes them on one host port, either per channel (DATA0/DATA1) or
// through a round-robin read (ARBDATA/ARBID). Also holds sticky overflow
// flags, the interrupt enable mask and the IRQ output.
//   SYSCLK, EXTRSTn  clock, async active-low reset
//   ch_data          2*DW result words, channel i in [DW*i +: DW]
//   ch_valid         one-cycle strobe per channel
//   host             slave side of the host bus (RD/WR/ADDR/WDATA/RDATA/IRQ)
module sd_result_arbiter
    import sd_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic                      SYSCLK,
    input  logic                      EXTRSTn,
    input  logic [SD_NUM_CH*DW-1:0]   ch_data,
    input  logic [SD_NUM_CH-1:0]      ch_valid,
    sd_result_arbiter_if.slave        host
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] fifo_rdata [SD_NUM_CH];
    logic [CW-1:0] fifo_count [SD_NUM_CH];
    logic [1:0]    fifo_full;
    logic [1:0]    fifo_empty;
    logic [1:0]    not_empty;
    logic [1:0]    pop;

    logic        rd_q, wr_q, rd_edge, wr_edge;
    logic [3:0]  ier;
    logic [1:0]  ovf, ovf_set, ovf_clr, pending;
    logic        last_grant, grant, arb_valid;
    logic [1:0]  arbid;
    logic [31:0] rdata_q, rd_mux, data0_word, data1_word;
    logic        irq_q;
    logic        sel_stat, sel_ier, sel_iclr, sel_data0, sel_data1, sel_arb, sel_arbid;
    logic        unused_wdata;

    for (genvar i = 0; i < SD_NUM_CH; i++) begin : g_fifo
        sd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .SYSCLK  (SYSCLK),
            .EXTRSTn (EXTRSTn),
            .push    (ch_valid[i]),
            .wdata   (ch_data[DW*i +: DW]),
            .pop     (pop[i]),
            .rdata   (fifo_rdata[i]),
            .count   (fifo_count[i]),
            .full    (fifo_full[i]),
            .empty   (fifo_empty[i])
        );
        assign not_empty[i] = (fifo_count[i] != '0);
    end

    assign unused_wdata = ^host.WDATA[31:6];

    // Address decode, access edges, arbitration and flag updates
    always_comb begin
        rd_edge   = host.RD & ~rd_q;
        wr_edge   = host.WR & ~wr_q;
        sel_stat  = (host.ADDR == AW'(SD_ADDR_STAT));
        sel_ier   = (host.ADDR == AW'(SD_ADDR_IER));
        sel_iclr  = (host.ADDR == AW'(SD_ADDR_ICLR));
        sel_data0 = (host.ADDR == AW'(SD_ADDR_DATA0));
        sel_data1 = (host.ADDR == AW'(SD_ADDR_DATA1));
        sel_arb   = (host.ADDR == AW'(SD_ADDR_ARBDATA));
        sel_arbid = (host.ADDR == AW'(SD_ADDR_ARBID));

        // Alternate when both have data, otherwise take whichever has data
        arb_valid = |not_empty;
        grant     = (&not_empty) ? ~last_grant : not_empty[1];

        pop[0] = rd_edge & ~fifo_empty[0] &
                 (sel_data0 | (sel_arb & arb_valid & ~grant));
        pop[1] = rd_edge & ~fifo_empty[1] &
                 (sel_data1 | (sel_arb & arb_valid & grant));

        // A pop in the same cycle frees room, so a full push is not lost
        ovf_set = ch_valid & fifo_full & ~pop;
        ovf_clr = {2{wr_edge & sel_iclr}} & host.WDATA[5:4];

        pending[0] = (not_empty[0] & ier[0]) | (ovf[0] & ier[2]);
        pending[1] = (not_empty[1] & ier[1]) | (ovf[1] & ier[3]);

        data0_word = fifo_empty[0] ? 32'd0 : 32'(fifo_rdata[0]);
        data1_word = fifo_empty[1] ? 32'd0 : 32'(fifo_rdata[1]);

        rd_mux = 32'd0;
        if (sel_stat) begin
            rd_mux[SD_STAT_NE_LSB   +: 2] = not_empty;
            rd_mux[SD_STAT_FULL_LSB +: 2] = fifo_full;
            rd_mux[SD_STAT_OVF_LSB  +: 2] = ovf;
            rd_mux[SD_STAT_PEND_LSB +: 2] = pending;
        end else if (sel_ier) begin
            rd_mux[3:0] = ier;
        end else if (sel_data0) begin
            rd_mux = data0_word;
        end else if (sel_data1) begin
            rd_mux = data1_word;
        end else if (sel_arb) begin
            if (arb_valid) begin
                rd_mux = grant ? data1_word : data0_word;
            end
        end else if (sel_arbid) begin
            rd_mux[1:0] = arbid;
        end
    end

    // Host-visible registers; set of an overflow wins over a same-cycle clear
    always_ff @(posedge SYSCLK or negedge EXTRSTn) begin
        if (!EXTRSTn) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ier        <= '0;
            ovf        <= '0;
            last_grant <= 1'b1;
            arbid      <= ARBID_NONE;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            rd_q  <= host.RD;
            wr_q  <= host.WR;
            ovf   <= (ovf & ~ovf_clr) | ovf_set;
            irq_q <= |pending;
            if (wr_edge && sel_ier) begin
                ier <= host.WDATA[3:0];
            end
            if (rd_edge) begin
                rdata_q <= rd_mux;
                if (sel_arb) begin
                    if (arb_valid) begin
                        last_grant <= grant;
                        arbid      <= {1'b0, grant};
                    end else begin
                        arbid <= ARBID_NONE;
                    end
                end
            end
        end
    end

    assign host.RDATA = rdata_q;
    assign host.IRQ   = irq_q;
endmodule
